adder_pipe_nbit: RTL
====================

Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined N-bit adder/subtractor; the next generation of the team's 4-bit ripple full adder.
- Operands are split into CHUNK-bit slices. One slice is resolved per pipeline stage, with the carry registered between stages.
- Valid/ready handshakes on input and output. Sits between operand sources and result consumers in datapaths that need a high clock rate.
- Throughput is one operation per cycle; latency is STAGES cycles.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; 1 <= CHUNK <= WIDTH.
- STAGES, WIDTH/CHUNK, derived (localparam); pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (borrow-in when sub=1, inverted sense)
- sub  input  1  0: a+b+cin; 1: a+~b+(~cin), i.e. a-b-cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out; for sub=1 it means 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: one clock domain. rst_n is asynchronous and active-low; the clock and reset ports are named clk and rst_n.
  - While rst_n=0: every stage valid bit, s, cout, ovf and out_valid are 0. in_ready=1 from the cycle after rst_n rises.
- Accept: a beat transfers when in_valid && in_ready at a rising clk edge.
- Operand conditioning at accept:
  - beff = sub ? ~b : b
  - c0 = cin ^ sub
- Stage k (0..STAGES-1):
  - Computes sum chunk k = a[k] + beff[k] + carry_k. carry_0 = c0; carry_k is the registered carry-out of stage k-1.
  - Forwards the upper unprocessed operand chunks.
  - Forwards the already-resolved lower sum chunks (skewed pipeline).
- Output registers:
  - The final stage registers s, cout = carry out of the MSB, and ovf = carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is captured inside the last stage.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1 when unstalled. For STAGES=1 it appears one cycle after acceptance.
- Flow control: a single global advance enable, adv = !out_valid || out_ready.
  - in_ready = adv.
  - On adv, all stages shift and each stage valid bit takes its predecessor's valid bit; stage 0 takes in_valid && in_ready.
  - When adv=0, all stage registers hold.
  - s, cout and ovf must remain stable while out_valid=1 && out_ready=0.
- Bubbles: stages with valid=0 still shift. Data in invalid stages is don't-care, but outputs are gated to 0 when out_valid=0.
- Simultaneous events:
  - Output-taken and new-input-accepted in the same cycle is legal and sustains full throughput.
  - in_valid with out_ready held low fills at most STAGES entries, then in_ready drops.
- Ordering: results leave strictly in acceptance order, with no loss or duplication.
- Reset mid-operation: all in-flight beats are discarded immediately. No stale result appears after reset release.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only via cout and ovf.

Decomposition:
- Package adder_pipe_pkg:
  - localparam helpers for STAGES.
  - Chunk index function.
  - Elaboration-time check macro for WIDTH % CHUNK == 0.
- Sub-module adder_chunk_stage:
  - One pipeline slice: CHUNK-bit add, carry register, valid register, pass-through of operand and sum vectors.
  - Instantiated STAGES times by generate.
  - The top level holds operand conditioning, the advance logic and output gating.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> out_valid=0, s=0, cout=0, ovf=0 asynchronously; in_ready=1 after release.
- Carry ripple through every stage (WIDTH=16, CHUNK=4): a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles s=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0003, b=0x0005, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
- Stream with backpressure:
  - Drive 256 back-to-back random beats; toggle out_ready pseudo-randomly.
  - Required: in-order match against {cout,s} = a + beff + c0; outputs stable while stalled; no loss or duplication; exactly STAGES beats buffered when out_ready=0.
  - Repeat exhaustively at WIDTH=4, CHUNK=1 (all a, b, cin, sub).
- Reset mid-stream: 3 beats in flight, pulse rst_n=0 -> out_valid drops at once; no result observed after release until a new beat is accepted.

Source files
------------

// File: rtl/adder_pipe_pkg.sv
// Shared helpers for the chunked pipelined adder: default geometry, stage count and
// chunk bit offsets, plus an elaboration-time configuration check.
package adder_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // LSB position of chunk idx within an operand
    function automatic int chunk_lo(input int idx, input int chunk);
        return idx * chunk;
    endfunction

endpackage

`define ADDER_PIPE_CHECK_CFG(W, C) \
    if ((C) < 1 || (C) > (W) || ((W) % (C)) != 0) begin : g_bad_cfg \
        $error("adder_pipe: WIDTH must be a positive multiple of CHUNK"); \
    end

// File: rtl/adder_chunk_stage.sv
// One slice of the skewed adder pipeline: resolves chunk IDX, registers its carry,
// and forwards the operand and partial-sum vectors to the next slice.
module adder_chunk_stage
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_s,
    input  logic             i_c,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_ovf
);

    localparam int LO = chunk_lo(IDX, CHUNK);
    localparam int HI = LO + CHUNK - 1;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_s;
    logic             w_c_msb;

    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_ovf;

    always_comb begin
        w_sum     = {1'b0, i_a[HI:LO]} + {1'b0, i_b[HI:LO]} + {{CHUNK{1'b0}}, i_c};
        w_s       = i_s;
        w_s[HI:LO] = w_sum[CHUNK-1:0];
        // carry into the chunk's top bit, recovered from that bit's sum
        w_c_msb   = i_a[HI] ^ i_b[HI] ^ w_sum[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_valid;
        end
    end

    // ---- stage register boundary ----
    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_s   <= w_s;
            r_c   <= w_sum[CHUNK];
            r_ovf <= w_c_msb ^ w_sum[CHUNK];
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_s     = r_s;
    assign o_c     = r_c;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides; one CHUNK-bit
// slice resolved per stage, single global advance enable, gated outputs.
module adder_pipe_nbit
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    `ADDER_PIPE_CHECK_CFG(WIDTH, CHUNK)

    logic [STAGES:0][WIDTH-1:0] w_a;
    logic [STAGES:0][WIDTH-1:0] w_b;
    logic [STAGES:0][WIDTH-1:0] w_s;
    logic [STAGES:0]            w_c;
    logic [STAGES:0]            w_v;
    logic [STAGES-1:0]          w_ovf;
    logic                       w_adv;
    logic                       w_unused;

    // whole pipe moves together; a stalled head freezes every stage
    assign w_adv    = !w_v[STAGES] || out_ready;
    assign in_ready = w_adv;

    assign w_v[0] = in_valid && w_adv;
    assign w_a[0] = a;
    assign w_b[0] = sub ? ~b : b;
    assign w_c[0] = cin ^ sub;
    assign w_s[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_adv   (w_adv),
            .i_valid (w_v[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .i_s     (w_s[k]),
            .i_c     (w_c[k]),
            .o_valid (w_v[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1]),
            .o_s     (w_s[k+1]),
            .o_c     (w_c[k+1]),
            .o_ovf   (w_ovf[k])
        );
    end

    assign out_valid = w_v[STAGES];
    assign s         = out_valid ? w_s[STAGES] : '0;
    assign cout      = out_valid && w_c[STAGES];
    assign ovf       = out_valid && w_ovf[STAGES-1];

    assign w_unused = ^{w_a[STAGES], w_b[STAGES], w_ovf};

endmodule
